// File: rtl/fp_adder.sv
// ---------------------------------------------------------------------------
// fp_adder
//   Single-precision (binary32) floating-point accumulator. Every time the
//   block is idle it samples operand `a` together with the current running
//   sum, then walks ALIGN -> ADD -> NORM and writes the rounded result back
//   into the accumulator. One addition is in flight at a time.
//
//   Rounding is round-to-nearest, ties-to-even. Denormal inputs are treated
//   as zero. Results below the smallest normal flush to a signed zero.
//   NaN inputs and inf - inf produce the canonical quiet NaN 32'h7FC00000.
//
// Ports
//   clock   in   1   system clock, rising-edge active
//   nreset  in   1   asynchronous reset, ACTIVE-HIGH despite the name
//   a       in   32  binary32 operand, sampled on each rising edge while ready=1
//   sum     out  32  binary32 running sum (accumulator register)
//   ready   out  1   1 while idle; the next rising edge captures `a`
// ---------------------------------------------------------------------------
module fp_adder (
    input  logic        clock,
    input  logic        nreset,
    input  logic [31:0] a,
    output logic [31:0] sum,
    output logic        ready
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ADD   = 2'd2,
        NORM  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Captured operands: A is the incoming operand, B the accumulator value.
    logic [31:0] opA_q, opB_q;

    // Aligned operands. Mantissas carry the hidden bit at [26] and
    // guard/round/sticky in [2:0].
    logic        bigSign_q, smlSign_q;
    logic [7:0]  bigExp_q;
    logic [26:0] bigMant_q, smlMant_q;
    logic        special_q;
    logic [31:0] specialVal_q;

    // Raw mantissa sum/difference with a carry bit at [27].
    logic [27:0] addMant_q;

    logic [31:0] sum_q;

    assign sum   = sum_q;
    assign ready = (state_q == IDLE);

    // The sequence is fixed; every state lasts exactly one clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic [7:0]  expA, expB;
    logic [22:0] fracA, fracB;
    logic        zeroA, zeroB, nanA, nanB, infA, infB;
    logic [30:0] magA, magB;
    logic        aBigger;

    assign expA  = opA_q[30:23];
    assign expB  = opB_q[30:23];
    assign fracA = opA_q[22:0];
    assign fracB = opB_q[22:0];
    assign zeroA = (expA == 8'd0);
    assign zeroB = (expB == 8'd0);
    assign nanA  = (expA == 8'hFF) && (fracA != 23'd0);
    assign nanB  = (expB == 8'hFF) && (fracB != 23'd0);
    assign infA  = (expA == 8'hFF) && (fracA == 23'd0);
    assign infB  = (expB == 8'hFF) && (fracB == 23'd0);

    // Denormals compare as zero so the swap below never picks one as larger.
    assign magA    = zeroA ? 31'd0 : opA_q[30:0];
    assign magB    = zeroB ? 31'd0 : opB_q[30:0];
    assign aBigger = (magA >= magB);

    // NaN / infinity short-cut. The result is carried alongside the normal
    // datapath and substituted when the sum is written.
    logic        specialHit;
    logic [31:0] specialRes;

    always_comb begin
        specialHit = 1'b0;
        specialRes = 32'h0000_0000;
        if (nanA || nanB) begin
            specialHit = 1'b1;
            specialRes = QNAN;
        end else if (infA && infB) begin
            specialHit = 1'b1;
            specialRes = (opA_q[31] != opB_q[31]) ? QNAN : opA_q;
        end else if (infA) begin
            specialHit = 1'b1;
            specialRes = opA_q;
        end else if (infB) begin
            specialHit = 1'b1;
            specialRes = opB_q;
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: swap so the larger magnitude comes first, then shift the
    // smaller mantissa right, folding every bit shifted out into sticky.
    // ------------------------------------------------------------------
    logic        bigSignD, smlSignD, bigZero, smlZero;
    logic [7:0]  bigExpD, smlExp, expDiff;
    logic [22:0] bigFrac, smlFrac;
    logic [26:0] bigMantD, smlFull, smlShifted, lostMask, smlMantD;

    always_comb begin
        bigSignD   = aBigger ? opA_q[31] : opB_q[31];
        smlSignD   = aBigger ? opB_q[31] : opA_q[31];
        bigZero    = aBigger ? zeroA : zeroB;
        smlZero    = aBigger ? zeroB : zeroA;
        bigExpD    = aBigger ? expA : expB;
        smlExp     = aBigger ? expB : expA;
        bigFrac    = aBigger ? fracA : fracB;
        smlFrac    = aBigger ? fracB : fracA;
        bigMantD   = bigZero ? 27'd0 : {1'b1, bigFrac, 3'b000};
        smlFull    = smlZero ? 27'd0 : {1'b1, smlFrac, 3'b000};
        expDiff    = bigExpD - smlExp;
        smlShifted = 27'd0;
        lostMask   = 27'd0;
        if (expDiff >= 8'd27) begin
            // Whole operand lies below the round bit: only sticky survives.
            smlMantD = {26'd0, |smlFull};
        end else begin
            smlShifted = smlFull >> expDiff;
            lostMask   = (27'd1 << expDiff) - 27'd1;
            smlMantD   = smlShifted | {26'd0, |(smlFull & lostMask)};
        end
    end

    // ------------------------------------------------------------------
    // ADD: magnitude add or subtract; the larger operand's sign wins.
    // ------------------------------------------------------------------
    logic [27:0] addMantD;

    always_comb begin
        if (bigSign_q == smlSign_q) begin
            addMantD = {1'b0, bigMant_q} + {1'b0, smlMant_q};
        end else begin
            addMantD = {1'b0, bigMant_q} - {1'b0, smlMant_q};
        end
    end

    // ------------------------------------------------------------------
    // NORM: leading-zero count used for left normalisation after a
    // subtraction. Only meaningful when bit 27 (carry) is clear.
    // ------------------------------------------------------------------
    logic [4:0] lzc;
    logic       lzcFound;

    always_comb begin
        lzc      = 5'd0;
        lzcFound = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lzcFound && addMant_q[i]) begin
                lzc      = 5'(26 - i);
                lzcFound = 1'b1;
            end
        end
    end

    // Normalise, round to nearest even, and pack the final result. A
    // rounding carry turns 1.111..1 into 10.000..0, which only bumps the
    // exponent because the stored fraction is then all zeros.
    logic               carry, roundUp, roundCarry;
    logic [4:0]         lzcEff;
    logic [26:0]        normMant;
    logic [24:0]        rounded;
    logic [22:0]        fracOut;
    logic signed [9:0]  normExp;
    logic [31:0]        resultD;

    always_comb begin
        carry      = addMant_q[27];
        lzcEff     = carry ? 5'd0 : lzc;
        if (carry) begin
            normMant = {addMant_q[27:2], addMant_q[1] | addMant_q[0]};
        end else begin
            normMant = addMant_q[26:0] << lzcEff;
        end
        roundUp    = normMant[2] & (normMant[1] | normMant[0] | normMant[3]);
        rounded    = {1'b0, normMant[26:3]} + {24'd0, roundUp};
        roundCarry = rounded[24];
        fracOut    = roundCarry ? 23'd0 : rounded[22:0];
        normExp    = $signed({2'b00, bigExp_q}) + $signed({9'd0, carry})
                   - $signed({5'd0, lzcEff}) + $signed({9'd0, roundCarry});

        if (special_q) begin
            resultD = specialVal_q;
        end else if (addMant_q == 28'd0) begin
            // Exact cancellation (or 0 + 0) always yields +0.
            resultD = 32'h0000_0000;
        end else if (normExp <= 10'sd0) begin
            resultD = {bigSign_q, 31'd0};
        end else if (normExp >= 10'sd255) begin
            resultD = {bigSign_q, 8'hFF, 23'd0};
        end else begin
            resultD = {bigSign_q, normExp[7:0], fracOut};
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Each stage only loads its own
    // registers, so an asynchronous reset mid-operation simply discards
    // the partial work and the accumulator is never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            state_q      <= IDLE;
            opA_q        <= 32'd0;
            opB_q        <= 32'd0;
            bigSign_q    <= 1'b0;
            smlSign_q    <= 1'b0;
            bigExp_q     <= 8'd0;
            bigMant_q    <= 27'd0;
            smlMant_q    <= 27'd0;
            special_q    <= 1'b0;
            specialVal_q <= 32'd0;
            addMant_q    <= 28'd0;
            sum_q        <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    opA_q <= a;
                    opB_q <= sum_q;
                end
                ALIGN: begin
                    bigSign_q    <= bigSignD;
                    smlSign_q    <= smlSignD;
                    bigExp_q     <= bigExpD;
                    bigMant_q    <= bigMantD;
                    smlMant_q    <= smlMantD;
                    special_q    <= specialHit;
                    specialVal_q <= specialRes;
                end
                ADD: begin
                    addMant_q <= addMantD;
                end
                NORM: begin
                    sum_q <= resultD;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_adder.sv
// ---------------------------------------------------------------------------
// tb_fp_adder
//   Self-checking bench for fp_adder. Directed steps cover reset, basic
//   accumulation, cancellation, tie-to-even rounding, overflow, inf - inf
//   and an abort by reset mid-operation. Randomised pairs and a chained run
//   are compared against an exact-arithmetic reference model: operands are
//   expanded into wide integers, added exactly, and rounded once.
// ---------------------------------------------------------------------------
module tb_fp_adder;

    logic        clock;
    logic        nreset;
    logic [31:0] a;
    logic [31:0] sum;
    logic        ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] modelSum;

    fp_adder dut (
        .clock  (clock),
        .nreset (nreset),
        .a      (a),
        .sum    (sum),
        .ready  (ready)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Exact value of a binary32 number in units of 2^-149; denormals -> 0.
    function automatic logic [299:0] toWide(input logic [31:0] f);
        logic [299:0] w;
        w = 300'd0;
        if (f[30:23] != 8'd0) begin
            w = {276'd0, 1'b1, f[22:0]};
            w = w << (int'(f[30:23]) - 1);
        end
        return w;
    endfunction

    // Reference: exact sum, then a single round-to-nearest-even.
    function automatic logic [31:0] refAdd(input logic [31:0] x, input logic [31:0] y);
        logic         xNan, yNan, xInf, yInf, sign;
        logic [299:0] wx, wy, mag, keep, rem, half, one;
        int           p, e, sh;
        xNan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yNan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xInf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yInf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (xNan || yNan) return 32'h7FC0_0000;
        if (xInf && yInf) return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
        if (xInf) return x;
        if (yInf) return y;
        wx = toWide(x);
        wy = toWide(y);
        if (x[31] == y[31]) begin
            mag  = wx + wy;
            sign = x[31];
        end else if (wx >= wy) begin
            mag  = wx - wy;
            sign = x[31];
        end else begin
            mag  = wy - wx;
            sign = y[31];
        end
        if (mag == 300'd0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {sign, 31'd0};
        sh   = p - 23;
        one  = 300'd1;
        keep = mag >> sh;
        rem  = mag & ((one << sh) - one);
        half = (sh > 0) ? (one << (sh - 1)) : 300'd0;
        if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + one;
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, 8'(e), keep[22:0]};
    endfunction

    // Random operand whose exponent lies near baseExp; specials optional.
    function automatic logic [31:0] randFloat(input int baseExp, input bit allowSpecial);
        int   kind, ex;
        logic s;
        logic [22:0] fr;
        kind = int'($urandom_range(0, 15));
        s    = 1'($urandom_range(0, 1));
        fr   = 23'($urandom);
        if (allowSpecial && kind == 0) return {s, 31'd0};
        if (allowSpecial && kind == 1) return {s, 8'd0, fr | 23'd1};
        if (allowSpecial && kind == 2) return {s, 8'hFF, 23'd0};
        if (allowSpecial && kind == 3) return {s, 8'hFF, fr | 23'd1};
        ex = baseExp + int'($urandom_range(0, 60)) - 30;
        if (ex < 1) ex = 1;
        if (ex > 254) ex = 254;
        return {s, 8'(ex), fr};
    endfunction

    // One accumulate operation starting from a falling edge with ready=1.
    // Checks the 1,0,0,0,1 ready pattern and the written sum.
    task automatic applyStimulus(input logic [31:0] value, input logic [31:0] expected,
                                 input string tag);
        checkOutput({tag, "_readyIdle"}, {31'd0, ready}, 32'd1);
        a = value;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput({tag, "_readyBusy"}, {31'd0, ready}, 32'd0);
            @(posedge clock);
        end
        @(negedge clock);
        checkOutput({tag, "_readyDone"}, {31'd0, ready}, 32'd1);
        checkOutput({tag, "_sum"}, sum, expected);
        modelSum = expected;
    endtask

    // Two-cycle reset pulse, released on a falling edge.
    task automatic pulseReset();
        nreset = 1'b1;
        repeat (2) @(negedge clock);
        nreset   = 1'b0;
        modelSum = 32'h0000_0000;
    endtask

    initial begin
        logic [31:0] x, y, expect1, expect2;
        int          baseExp;

        nreset   = 1'b1;
        a        = 32'h0000_0000;
        modelSum = 32'h0000_0000;

        // Reset held for three cycles.
        repeat (3) @(negedge clock);
        checkOutput("reset_sum", sum, 32'h0000_0000);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        nreset = 1'b0;

        // Basic accumulation and cancellation.
        applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, "add_1p5");
        applyStimulus(32'h4040_0000, 32'h4090_0000, "add_3p0");
        applyStimulus(32'hC090_0000, 32'h0000_0000, "cancel");

        // Alignment and tie-to-even rounding around 1.0.
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, "load_1p0");
        applyStimulus(32'h3380_0000, 32'h3F80_0000, "tie_even");
        applyStimulus(32'h3400_0000, 32'h3F80_0001, "lsb_add");

        // Overflow to infinity, then inf + -inf.
        pulseReset();
        applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, "load_max");
        applyStimulus(32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
        applyStimulus(32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");

        // Abort by reset while the addition sits in the ADD state.
        a = 32'h3F80_0000;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        #2;
        nreset = 1'b1;
        #1;
        checkOutput("midop_sum", sum, 32'h0000_0000);
        checkOutput("midop_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clock);
        nreset   = 1'b0;
        modelSum = 32'h0000_0000;
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, "after_abort");

        // Random pairs against the reference model, including exact and
        // near-exact cancellation, extreme exponents and special values.
        for (int t = 0; t < 60; t++) begin
            pulseReset();
            baseExp = int'($urandom_range(1, 254));
            x = randFloat(baseExp, 1'b1);
            if (t % 5 == 0)      y = x ^ 32'h8000_0000;
            else if (t % 7 == 0) y = {~x[31], x[30:1], ~x[0]};
            else                 y = randFloat(int'(x[30:23]), 1'b1);
            expect1 = refAdd(x, modelSum);
            applyStimulus(x, expect1, "rand_first");
            expect2 = refAdd(y, modelSum);
            applyStimulus(y, expect2, "rand_pair");
        end

        // Chained accumulation of finite values of similar scale.
        pulseReset();
        for (int t = 0; t < 40; t++) begin
            x = randFloat(127, 1'b0);
            expect1 = refAdd(x, modelSum);
            applyStimulus(x, expect1, "rand_chain");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_adder.md
Name: fp_adder

Overview:
- Single-precision IEEE-754 floating-point accumulator.
- Each accepted operand `a` is added to the internal running sum. The result is exposed on `sum`.
- Multi-cycle, one addition in flight at a time. `ready` flags when the next operand is sampled.
- Sits as a standalone arithmetic block driven by a single clock domain.

Parameters:
- None. Format is fixed at binary32: 1 sign bit, 8-bit exponent (bias 127), 23-bit fraction.

Ports:
- clock   input   1   system clock; all state changes on its rising edge.
- nreset  input   1   asynchronous reset, active-high: asserted when 1, despite the name. Clears all state immediately.
- a       input   32  binary32 operand to add into the accumulator.
- sum     output  32  binary32 running sum (accumulator register).
- ready   output  1   1 = idle; `a` is sampled on this rising edge.

Behaviour:
- Reset (nreset=1, asynchronous):
  - sum = 32'h00000000; ready = 1; FSM = IDLE; internal operand/alignment registers cleared.
  - Deassertion takes effect at the next rising edge.
- FSM states: IDLE → ALIGN → ADD → NORM → IDLE. One state per clock.
- IDLE (ready=1):
  - On each rising edge, capture `a` and the current `sum` into operand registers.
  - Move to ALIGN; ready drops to 0 the cycle after capture.
  - Holding `a` constant therefore re-accumulates it every 4 cycles. This is intentional: no valid strobe exists.
- ALIGN:
  - Unpack both operands with hidden bit; exponent 0 ⇒ value treated as zero.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits.
  - Shift ≥ 27 ⇒ smaller operand collapses to sticky only.
- ADD:
  - Same signs: add mantissas.
  - Different signs: subtract smaller from larger.
  - Result sign = sign of the larger magnitude.
- NORM:
  - Carry-out ⇒ shift right 1, exponent +1.
  - Otherwise left-normalize via leading-zero count.
  - Round to nearest, ties to even, using guard/round/sticky. Rounding carry renormalizes.
  - Write `sum`; return to IDLE (ready=1 in the next cycle).
- Latency: operand captured at edge N; sum valid after edge N+3. Next capture occurs at edge N+4.
- Zero and denormal handling:
  - Exact cancellation gives +0 (32'h00000000).
  - Denormal inputs are flushed to zero.
  - Underflow below the minimum normal flushes to signed zero.
- Overflow: exponent ≥ 255 after rounding ⇒ ±infinity (8'hFF exponent, zero fraction).
- Special inputs:
  - Any NaN operand ⇒ sum = 32'h7FC00000.
  - Inf + finite ⇒ that inf.
  - +inf + −inf ⇒ 32'h7FC00000.
  - Inf + same-sign inf ⇒ that inf.
- Reset mid-operation: aborts the in-flight addition. Outputs return to reset values asynchronously; no partial result is written.
- X/unknown on `a` while ready=1 is a usage error. Benches must drive a defined value (0.0 is a safe idle value).

Test Plan:
- Reset: pulse nreset high 3 cycles → sum=32'h00000000, ready=1 immediately on assertion and after release.
- Basic accumulate: from 0, present a=32'h3FC00000 (1.5) for one capture → sum=32'h3FC00000. Then a=32'h40400000 (3.0) → sum=32'h40900000 (4.5). Check ready pattern 1,0,0,0,1 per operation.
- Cancellation: sum=4.5, a=32'hC0900000 (−4.5) → sum=32'h00000000.
- Rounding/alignment: sum=32'h3F800000 (1.0), a=32'h33800000 (2^-24) → sum stays 32'h3F800000 (tie to even). Then a=32'h34000000 (2^-23) → sum=32'h3F800001.
- Overflow/specials:
  - sum=32'h7F7FFFFF, a=32'h7F7FFFFF → sum=32'h7F800000.
  - Then a=32'hFF800000 → sum=32'h7FC00000.
- Reset mid-op: assert nreset during the ADD state → sum=0 and ready=1 within the same cycle; the next capture proceeds normally.
